// File: rtl/ex_mc_ctrl.sv
// Multi-cycle EX controller: sequences 32-step divides, divide-by-zero
// shortcut and two-cycle MAC, and generates the pipeline stall vector.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a multi-cycle request from EX
// DIVZ  | divisor is zero; one bubble before the default result
// DIV   | iterating, one step per cycle, 32 steps total
// MAC   | second multiply-accumulate cycle
// DONE  | result valid for one cycle, EX released
module ex_mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] op_i,
    input  logic       divisor_zero_i,
    input  logic       annul_i,
    input  logic       stallreq_id_i,
    output logic [5:0] stall_o,
    output logic       init_o,
    output logic       step_o,
    output logic [5:0] cnt_o,
    output logic       signed_o,
    output logic       done_o,
    output logic       zero_o,
    output logic       busy_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DIVZ = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_MAC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MAC  = 2'b11;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       zero_q;
    logic       accept;
    logic       running;
    logic       ex_stall;

    always_comb begin
        accept   = (state == ST_IDLE) & start_i & (op_i != OP_NONE) & ~annul_i & ~rst;
        running  = (state == ST_DIVZ) | (state == ST_DIV) | (state == ST_MAC);
        ex_stall = accept | (running & ~annul_i);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_i == OP_MAC)
                        state_nxt = ST_MAC;
                    else if (divisor_zero_i)
                        state_nxt = ST_DIVZ;
                    else
                        state_nxt = ST_DIV;
                end
            end
            ST_DIVZ: state_nxt = annul_i ? ST_IDLE : ST_DONE;
            ST_DIV: begin
                if (annul_i)
                    state_nxt = ST_IDLE;
                else if (cnt_o == 6'd31)
                    state_nxt = ST_DONE;
            end
            ST_MAC:  state_nxt = annul_i ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_o    <= 6'd0;
            signed_o <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            // DIVZ always precedes DONE by one cycle, so this marks the default result
            zero_q <= (state == ST_DIVZ);
            if (accept) begin
                cnt_o    <= 6'd0;
                signed_o <= (op_i == OP_DIV);
            end else if ((state == ST_DIV) && !annul_i) begin
                cnt_o <= cnt_o + 6'd1;
            end
        end
    end

    always_comb begin
        init_o = accept;
        step_o = ~rst & ~annul_i & ((state == ST_DIV) | (state == ST_MAC));
        done_o = (state == ST_DONE);
        zero_o = ~rst & done_o & zero_q;
        busy_o = ~rst & (state != ST_IDLE);
        if (rst)
            stall_o = 6'b000000;
        else if (ex_stall)
            stall_o = STALL_EX;
        else if (running & annul_i)
            stall_o = 6'b000000;  // flush: release the whole pipe in the annul cycle
        else if (stallreq_id_i)
            stall_o = STALL_ID;
        else
            stall_o = 6'b000000;
    end

endmodule
